// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures hsync/vsync timing, locks after
// consistent frames and recovers active-pixel coordinates.
module vga_sync_decoder #(
   parameter int unsigned HW          = 11,
   parameter int unsigned VW          = 10,
   parameter int unsigned ACTIVE_H    = 640,
   parameter int unsigned ACTIVE_V    = 480,
   parameter int unsigned H_START     = 144,
   parameter int unsigned V_START     = 35,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hsync_in,
   input  logic          vsync_in,
   output logic          locked,
   output logic          frame_start,
   output logic          active_out,
   output logic [HW-1:0] pix_x,
   output logic [VW-1:0] pix_y,
   output logic [HW-1:0] h_total_meas,
   output logic [HW-1:0] h_sync_meas,
   output logic [VW-1:0] v_total_meas,
   output logic [VW-1:0] v_sync_meas
);

   localparam int unsigned FW = $clog2(LOCK_FRAMES + 1);
   localparam logic [FW-1:0] LOCK_N = FW'(LOCK_FRAMES);
   localparam logic [HW-1:0] H_LO   = HW'(H_START);
   localparam logic [HW-1:0] H_HI   = HW'(H_START + ACTIVE_H);
   localparam logic [VW-1:0] V_LO   = VW'(V_START);
   localparam logic [VW-1:0] V_HI   = VW'(V_START + ACTIVE_V);

   logic          hs_q, vs_q;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [FW-1:0] frames_ok, frames_ok_nxt;
   logic          line_err;

   logic          hs_fall, hs_rise, vs_fall, vs_rise;
   logic          h_sat, line_bad, frame_good;
   logic [HW-1:0] h_len;
   logic [VW-1:0] v_len;

   assign hs_fall = hs_q & ~hsync_in;
   assign hs_rise = ~hs_q & hsync_in;
   assign vs_fall = vs_q & ~vsync_in;
   assign vs_rise = ~vs_q & vsync_in;

   assign h_sat    = &h_cnt;
   assign h_len    = h_cnt + 1'b1;
   assign v_len    = v_cnt + VW'(hs_fall);
   assign line_bad = hs_fall && (h_total_meas != '0) && (h_len != h_total_meas);

   // A line ending on the vsync-fall cycle belongs to the frame that is closing,
   // so its mismatch and any timeout are folded into this frame's verdict.
   assign frame_good = (v_total_meas != '0) && (v_len == v_total_meas) &&
                       !line_err && !line_bad && !h_sat;

   always_comb begin
      frames_ok_nxt = frames_ok;
      if (vs_fall) begin
         if (frame_good)
            frames_ok_nxt = (frames_ok == LOCK_N) ? LOCK_N : frames_ok + 1'b1;
         else
            frames_ok_nxt = '0;
      end
      if (line_bad || h_sat)
         frames_ok_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         h_cnt        <= '0;
         v_cnt        <= '0;
         h_total_meas <= '0;
         h_sync_meas  <= '0;
         v_total_meas <= '0;
         v_sync_meas  <= '0;
         line_err     <= 1'b0;
         frames_ok    <= '0;
         locked       <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         hs_q <= hsync_in;
         vs_q <= vsync_in;

         if (hs_fall) begin
            h_cnt        <= '0;
            h_total_meas <= h_len;
         end else if (!h_sat) begin
            h_cnt <= h_len;
         end
         if (hs_rise)
            h_sync_meas <= h_len;

         if (vs_fall) begin
            v_cnt        <= '0;
            v_total_meas <= v_len;
         end else if (hs_fall && !(&v_cnt)) begin
            v_cnt <= v_cnt + 1'b1;
         end
         if (vs_rise)
            v_sync_meas <= v_len;

         line_err    <= vs_fall ? 1'b0 : (line_err | line_bad | h_sat);
         frames_ok   <= frames_ok_nxt;
         locked      <= (frames_ok_nxt == LOCK_N);
         frame_start <= vs_fall;
      end
   end

   assign active_out = locked && (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                       (v_cnt >= V_LO) && (v_cnt < V_HI);
   assign pix_x = active_out ? h_cnt - H_LO : '0;
   assign pix_y = active_out ? v_cnt - V_LO : '0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced raster (40 clk lines, 12-line frames)
// with a timestamp-based reference model and directed literal checks.
module tb_vga_sync_decoder;

   localparam int unsigned HW = 11;
   localparam int unsigned VW = 10;
   localparam int AH = 24, AV = 6, HS = 8, VS = 3, LF = 2;
   localparam int LINE = 40, HLOW = 4, LINES = 12, VLOW = 2;
   localparam int HMAX = 2047, VMAX = 1023;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hsync_in = 1'b1;
   logic          vsync_in = 1'b1;
   logic          locked, frame_start, active_out;
   logic [HW-1:0] pix_x, h_total_meas, h_sync_meas;
   logic [VW-1:0] pix_y, v_total_meas, v_sync_meas;

   vga_sync_decoder #(
      .HW(HW), .VW(VW), .ACTIVE_H(AH), .ACTIVE_V(AV),
      .H_START(HS), .V_START(VS), .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .locked(locked), .frame_start(frame_start), .active_out(active_out),
      .pix_x(pix_x), .pix_y(pix_y),
      .h_total_meas(h_total_meas), .h_sync_meas(h_sync_meas),
      .v_total_meas(v_total_meas), .v_sync_meas(v_sync_meas)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad_n = 0;

   // Reference model: counters are derived from edge timestamps and line tallies.
   int  n = 0;
   bit  mvalid = 1'b0;
   int  hf_ref, lines, hm_t, hm_s, vm_t, vm_s, fok, e_h, e_v;
   bit  mbad, pv_hs, pv_vs, e_lock, e_fs;

   always @(posedge clk) begin
      int hb, len, cnt;
      bit hf, hr, vf, vr, lb, to;
      n++;
      if (rst) begin
         mvalid = 1'b1;
         hf_ref = n; lines = 0;
         hm_t = 0; hm_s = 0; vm_t = 0; vm_s = 0;
         fok = 0; mbad = 1'b0; pv_hs = 1'b1; pv_vs = 1'b1; e_fs = 1'b0;
      end else if (mvalid) begin
         hb = n - 1 - hf_ref;
         if (hb > HMAX) hb = HMAX;
         hf  = pv_hs && !hsync_in;
         hr  = !pv_hs && hsync_in;
         vf  = pv_vs && !vsync_in;
         vr  = !pv_vs && vsync_in;
         to  = (hb == HMAX);
         len = (hb + 1) % (HMAX + 1);
         lb  = hf && (hm_t != 0) && (len != hm_t);
         cnt = (lines + int'(hf)) % (VMAX + 1);
         if (vf)
            fok = (vm_t != 0 && cnt == vm_t && !mbad && !lb && !to) ?
                  ((fok < LF) ? fok + 1 : LF) : 0;
         if (lb || to) fok = 0;
         mbad = vf ? 1'b0 : (mbad || lb || to);
         if (hf) begin hm_t = len; hf_ref = n; end
         if (hr) hm_s = len;
         if (vf) begin vm_t = cnt; lines = 0; end
         else if (hf && lines < VMAX) lines++;
         if (vr) vm_s = cnt;
         e_fs  = vf;
         pv_hs = hsync_in;
         pv_vs = vsync_in;
      end
      e_h    = (n - hf_ref > HMAX) ? HMAX : n - hf_ref;
      e_v    = lines;
      e_lock = (fok == LF);
   end

   always @(negedge clk) begin
      bit e_act;
      int ex, ey;
      if (mvalid) begin
         e_act = e_lock && e_h >= HS && e_h < HS + AH && e_v >= VS && e_v < VS + AV;
         ex = e_act ? e_h - HS : 0;
         ey = e_act ? e_v - VS : 0;
         total++;
         if (locked !== e_lock || frame_start !== e_fs || active_out !== e_act ||
             int'(pix_x) != ex || int'(pix_y) != ey ||
             int'(h_total_meas) != hm_t || int'(h_sync_meas) != hm_s ||
             int'(v_total_meas) != vm_t || int'(v_sync_meas) != vm_s) begin
            bad_n++;
            $display("FAIL model_cmp t=%0t got lk=%0b fs=%0b act=%0b x=%0d y=%0d ht=%0d hs=%0d vt=%0d vs=%0d exp lk=%0b fs=%0b act=%0b x=%0d y=%0d ht=%0d hs=%0d vt=%0d vs=%0d",
                     $time, locked, frame_start, active_out, pix_x, pix_y,
                     h_total_meas, h_sync_meas, v_total_meas, v_sync_meas,
                     e_lock, e_fs, e_act, ex, ey, hm_t, hm_s, vm_t, vm_s);
         end
      end
   end

   // Observations used by the directed checks
   int fs_q[$];
   int act_cnt, max_x, max_y, min_x, min_y;
   always @(negedge clk) begin
      if (frame_start === 1'b1) fs_q.push_back(int'(locked));
      if (active_out === 1'b1) begin
         act_cnt++;
         if (int'(pix_x) > max_x) max_x = int'(pix_x);
         if (int'(pix_y) > max_y) max_y = int'(pix_y);
         if (int'(pix_x) < min_x) min_x = int'(pix_x);
         if (int'(pix_y) < min_y) min_y = int'(pix_y);
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad_n++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_fs(input string name, input int e0, input int e1, input int e2,
                         input int e3, input int e4, input int cnt);
      int exp[5];
      exp = '{e0, e1, e2, e3, e4};
      chk({name, "_pulses"}, fs_q.size(), cnt);
      for (int k = 0; k < cnt; k++)
         chk($sformatf("%s_lock_at_fs%0d", name, k),
             (k < fs_q.size()) ? fs_q[k] : -1, exp[k]);
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, "_locked"}, int'(locked), 0);
      chk({name, "_frame_start"}, int'(frame_start), 0);
      chk({name, "_active"}, int'(active_out), 0);
      chk({name, "_pix_x"}, int'(pix_x), 0);
      chk({name, "_pix_y"}, int'(pix_y), 0);
      chk({name, "_h_total"}, int'(h_total_meas), 0);
      chk({name, "_h_sync"}, int'(h_sync_meas), 0);
      chk({name, "_v_total"}, int'(v_total_meas), 0);
      chk({name, "_v_sync"}, int'(v_sync_meas), 0);
   endtask

   bit unlock_chk = 1'b0;

   // One line: hsync low for HLOW clocks; optional mid-line reset pulse.
   task automatic line(input int len, input bit vlow, input int rst_at);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (rst_at >= 0 && i == rst_at + 1) begin
            chk_zero_outputs("midframe_rst");
            rst = 1'b0;
         end
         if (i == 1 && unlock_chk) begin
            chk("unlock_next_cycle", int'(locked), 0);
            unlock_chk = 1'b0;
         end
         hsync_in = (i >= HLOW);
         vsync_in = !vlow;
         if (i == rst_at) rst = 1'b1;
      end
   endtask

   task automatic frame(input int long_line, input int rst_line);
      for (int l = 0; l < LINES; l++) begin
         line((l == long_line) ? LINE + 1 : LINE, l < VLOW, (l == rst_line) ? 10 : -1);
         if (l == long_line) unlock_chk = 1'b1;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Lock acquisition: partial, first full, then two matching frames
      fs_q.delete();
      repeat (5) frame(-1, -1);
      chk_fs("acquire", 0, 0, 0, 1, 1, 5);
      chk("h_total", int'(h_total_meas), LINE);
      chk("h_sync", int'(h_sync_meas), HLOW);
      chk("v_total_coincident", int'(v_total_meas), LINES);
      chk("v_sync", int'(v_sync_meas), VLOW);

      // Active window over one locked frame
      act_cnt = 0; max_x = -1; max_y = -1; min_x = 9999; min_y = 9999;
      frame(-1, -1);
      chk("active_cycles", act_cnt, AH * AV);
      chk("pix_x_min", min_x, 0);
      chk("pix_x_max", max_x, AH - 1);
      chk("pix_y_min", min_y, 0);
      chk("pix_y_max", max_y, AV - 1);

      // Stretched line drops lock, two clean frames relock
      fs_q.delete();
      frame(5, -1);
      repeat (3) frame(-1, -1);
      chk_fs("stretch", 1, 0, 0, 1, 0, 4);
      chk("unlock_check_reached", int'(unlock_chk), 0);

      // hsync timeout
      hsync_in = 1'b1; vsync_in = 1'b1;
      repeat (2100) @(negedge clk);
      chk("timeout_locked", int'(locked), 0);
      chk("timeout_h_total", int'(h_total_meas), LINE);
      chk("timeout_h_sync", int'(h_sync_meas), HLOW);
      chk("timeout_v_total", int'(v_total_meas), LINES);
      chk("timeout_v_sync", int'(v_sync_meas), VLOW);
      fs_q.delete();
      repeat (3) frame(-1, -1);
      chk_fs("after_timeout", 0, 0, 1, 0, 0, 3);

      // Reset in the middle of a locked frame
      fs_q.delete();
      frame(-1, 6);
      repeat (4) frame(-1, -1);
      chk_fs("after_rst", 1, 0, 0, 0, 1, 5);
      chk("rst_v_total", int'(v_total_meas), LINES);

      $display("test done: total=%0d bad=%0d", total, bad_n);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
